// File: rtl/dp_tap_ctrl_if.sv
// JTAG pin and boundary-scan chain bundle for dp_tap_ctrl.
// The slave side is the TAP controller; the master side is the pin/chain environment.
interface dp_tap_ctrl_if;
   logic       tck;
   logic       tms;
   logic       tdi;
   logic       tdo;
   logic       tdo_en;
   logic       bsr_si;
   logic       bsr_so;
   logic       shift_dr;
   logic       clk_dr;
   logic       update_dr;
   logic       mode;
   logic [3:0] tap_state;

   modport master (
      output tck, tms, tdi, bsr_so,
      input  tdo, tdo_en, bsr_si, shift_dr, clk_dr, update_dr, mode, tap_state
   );

   modport slave (
      input  tck, tms, tdi, bsr_so,
      output tdo, tdo_en, bsr_si, shift_dr, clk_dr, update_dr, mode, tap_state
   );
endinterface

// File: rtl/dp_tap_ctrl.sv
// Oversampled IEEE 1149.1 TAP controller in the iclk domain driving a boundary-scan chain.
// Optional IDCODE data register is enabled by defining DP_TAP_IDCODE_EN.
module dp_tap_ctrl #(
   parameter int unsigned      IR_W       = 4,
   parameter logic [IR_W-1:0]  EXTEST     = 4'b0000,
`ifdef DP_TAP_IDCODE_EN
   parameter logic [IR_W-1:0]  IDCODE_OP  = 4'b0010,
   parameter logic [31:0]      IDCODE_VAL = 32'h1000_0001,
`endif
   parameter logic [IR_W-1:0]  SAMPLE     = 4'b0001
) (
   input  logic           iclk,
   input  logic           resetn,
   dp_tap_ctrl_if.slave   bus
);

   typedef enum logic [3:0] {
      TLR      = 4'hF, RTI      = 4'hC,
      SEL_DR   = 4'h7, CAP_DR   = 4'h6, SH_DR    = 4'h2, EX1_DR   = 4'h1,
      PAUSE_DR = 4'h3, EX2_DR   = 4'h0, UPD_DR   = 4'h5,
      SEL_IR   = 4'h4, CAP_IR   = 4'hE, SH_IR    = 4'hA, EX1_IR   = 4'h9,
      PAUSE_IR = 4'hB, EX2_IR   = 4'h8, UPD_IR   = 4'hD
   } tap_state_e;

   localparam logic [IR_W-1:0] IR_CAP = IR_W'(2'b01);
`ifdef DP_TAP_IDCODE_EN
   localparam logic [IR_W-1:0] IR_RST = IDCODE_OP;
`else
   localparam logic [IR_W-1:0] IR_RST = {IR_W{1'b1}};
`endif

   logic [1:0]      tck_sync_r;
   logic [1:0]      tms_sync_r;
   logic [1:0]      tdi_sync_r;
   logic            tck_dly_r;
   logic            tck_rise_s;
   logic            tck_fall_s;
   logic            tms_s;
   logic            tdi_s;
   tap_state_e      state_r;
   tap_state_e      state_nxt_s;
   logic [IR_W-1:0] ir_sr_r;
   logic [IR_W-1:0] ir_r;
   logic            bypass_r;
   logic            bsr_sel_s;
   logic            dr_tdo_s;
   logic            tdo_r;
   logic            tdo_en_r;
   logic            shift_dr_r;
   logic            clk_dr_r;
   logic            update_dr_r;
`ifdef DP_TAP_IDCODE_EN
   logic [31:0]     idcode_sr_r;
`endif

   // Two-flop synchronisers plus a tck delay flop for edge detection.
   always_ff @(posedge iclk or negedge resetn) begin
      if (!resetn) begin
         tck_sync_r <= 2'b00;
         tms_sync_r <= 2'b00;
         tdi_sync_r <= 2'b00;
         tck_dly_r  <= 1'b0;
      end else begin
         tck_sync_r <= {tck_sync_r[0], bus.tck};
         tms_sync_r <= {tms_sync_r[0], bus.tms};
         tdi_sync_r <= {tdi_sync_r[0], bus.tdi};
         tck_dly_r  <= tck_sync_r[1];
      end
   end

   assign tms_s      = tms_sync_r[1];
   assign tdi_s      = tdi_sync_r[1];
   assign tck_rise_s = tck_sync_r[1] & ~tck_dly_r;
   assign tck_fall_s = ~tck_sync_r[1] & tck_dly_r;
   assign bsr_sel_s  = (ir_r == EXTEST) || (ir_r == SAMPLE);

   // TAP state register.
   always_ff @(posedge iclk or negedge resetn) begin
      if (!resetn) begin
         state_r <= TLR;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // 1149.1 state transitions, taken only on a synchronised tck rising edge.
   always_comb begin
      state_nxt_s = state_r;
      if (tck_rise_s) begin
         case (state_r)
            TLR:      state_nxt_s = tms_s ? TLR    : RTI;
            RTI:      state_nxt_s = tms_s ? SEL_DR : RTI;
            SEL_DR:   state_nxt_s = tms_s ? SEL_IR : CAP_DR;
            CAP_DR:   state_nxt_s = tms_s ? EX1_DR : SH_DR;
            SH_DR:    state_nxt_s = tms_s ? EX1_DR : SH_DR;
            EX1_DR:   state_nxt_s = tms_s ? UPD_DR : PAUSE_DR;
            PAUSE_DR: state_nxt_s = tms_s ? EX2_DR : PAUSE_DR;
            EX2_DR:   state_nxt_s = tms_s ? UPD_DR : SH_DR;
            UPD_DR:   state_nxt_s = tms_s ? SEL_DR : RTI;
            SEL_IR:   state_nxt_s = tms_s ? TLR    : CAP_IR;
            CAP_IR:   state_nxt_s = tms_s ? EX1_IR : SH_IR;
            SH_IR:    state_nxt_s = tms_s ? EX1_IR : SH_IR;
            EX1_IR:   state_nxt_s = tms_s ? UPD_IR : PAUSE_IR;
            PAUSE_IR: state_nxt_s = tms_s ? EX2_IR : PAUSE_IR;
            EX2_IR:   state_nxt_s = tms_s ? UPD_IR : SH_IR;
            UPD_IR:   state_nxt_s = tms_s ? SEL_DR : RTI;
            default:  state_nxt_s = TLR;
         endcase
      end else begin
         state_nxt_s = state_r;
      end
   end

   // Chain strobes; shift_dr is registered alongside clk_dr so the cell sees them together.
   always_ff @(posedge iclk or negedge resetn) begin
      if (!resetn) begin
         shift_dr_r  <= 1'b0;
         clk_dr_r    <= 1'b0;
         update_dr_r <= 1'b0;
      end else begin
         shift_dr_r  <= bsr_sel_s && (state_r == SH_DR);
         clk_dr_r    <= tck_rise_s && bsr_sel_s && ((state_r == CAP_DR) || (state_r == SH_DR));
         update_dr_r <= tck_fall_s && bsr_sel_s && (state_r == UPD_DR);
      end
   end

   // Instruction shift and active registers; TLR holds the active IR at its reset value.
   always_ff @(posedge iclk or negedge resetn) begin
      if (!resetn) begin
         ir_sr_r <= {IR_W{1'b0}};
         ir_r    <= IR_RST;
      end else begin
         if (tck_rise_s && (state_r == CAP_IR)) begin
            ir_sr_r <= IR_CAP;
         end else if (tck_rise_s && (state_r == SH_IR)) begin
            ir_sr_r <= {tdi_s, ir_sr_r[IR_W-1:1]};
         end
         if (state_r == TLR) begin
            ir_r <= IR_RST;
         end else if (tck_fall_s && (state_r == UPD_IR)) begin
            ir_r <= ir_sr_r;
         end
      end
   end

   // Internal data registers: BYPASS and, when enabled, IDCODE.
   always_ff @(posedge iclk or negedge resetn) begin
      if (!resetn) begin
         bypass_r    <= 1'b0;
`ifdef DP_TAP_IDCODE_EN
         idcode_sr_r <= 32'h0000_0000;
`endif
      end else if (tck_rise_s) begin
         if (state_r == CAP_DR) begin
            bypass_r <= 1'b0;
         end else if (state_r == SH_DR) begin
            bypass_r <= tdi_s;
         end
`ifdef DP_TAP_IDCODE_EN
         if ((state_r == CAP_DR) && (ir_r == IDCODE_OP)) begin
            idcode_sr_r <= IDCODE_VAL;
         end else if (state_r == SH_DR) begin
            idcode_sr_r <= {tdi_s, idcode_sr_r[31:1]};
         end
`endif
      end
   end

   // Data register select for tdo.
   always_comb begin
      dr_tdo_s = bypass_r;
      if (bsr_sel_s) begin
         dr_tdo_s = bus.bsr_so;
`ifdef DP_TAP_IDCODE_EN
      end else if (ir_r == IDCODE_OP) begin
         dr_tdo_s = idcode_sr_r[0];
`endif
      end else begin
         dr_tdo_s = bypass_r;
      end
   end

   // tdo/tdo_en change only on tck falling edges; tdo holds outside the shift states.
   always_ff @(posedge iclk or negedge resetn) begin
      if (!resetn) begin
         tdo_r    <= 1'b0;
         tdo_en_r <= 1'b0;
      end else if (tck_fall_s) begin
         tdo_en_r <= (state_r == SH_DR) || (state_r == SH_IR);
         if (state_r == SH_IR) begin
            tdo_r <= ir_sr_r[0];
         end else if (state_r == SH_DR) begin
            tdo_r <= dr_tdo_s;
         end
      end
   end

   assign bus.tdo       = tdo_r;
   assign bus.tdo_en    = tdo_en_r;
   assign bus.bsr_si    = tdi_s;
   assign bus.shift_dr  = shift_dr_r;
   assign bus.clk_dr    = clk_dr_r;
   assign bus.update_dr = update_dr_r;
   assign bus.mode      = (ir_r == EXTEST);
   assign bus.tap_state = state_r;

endmodule

// File: tb/tb_dp_tap_ctrl.sv
// Self-checking bench for dp_tap_ctrl: TAP state table model, 8-cell scan chain model,
// randomized opcodes/data, and directed reset/TLR scenarios.
module tb_dp_tap_ctrl;

   localparam logic [3:0]  S_TLR  = 4'hF;
   localparam logic [3:0]  S_RTI  = 4'hC;
   localparam logic [31:0] IDV    = 32'h1000_0001;
   // Next-state tables indexed by state code: nibble k is the successor of state k.
   localparam logic [63:0] NS0    = 64'hCACC_BABA_62CE_3232;
   localparam logic [63:0] NS1    = 64'hF977_89DD_417F_0155;
`ifdef DP_TAP_IDCODE_EN
   localparam logic [3:0]  IR_RST = 4'b0010;
`else
   localparam logic [3:0]  IR_RST = 4'b1111;
`endif

   logic       iclk = 1'b0;
   logic       resetn;
   logic [3:0] st_m;
   logic [7:0] pins;
   logic [7:0] chain_cap = 8'h00;
   logic [7:0] chain_upd = 8'h00;
   int         cap_cnt   = 0;
   int         sh_cnt    = 0;
   int         upd_cnt   = 0;
   int         checks    = 0;
   int         failures  = 0;

   dp_tap_ctrl_if bus ();

   dp_tap_ctrl dut (
      .iclk   (iclk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 iclk = ~iclk;

   assign bus.bsr_so = chain_cap[0];

   // Eight boundary-scan cells: capture pins, shift toward bsr_so, update latch.
   always @(posedge iclk) begin
      if (bus.clk_dr) begin
         if (bus.shift_dr) begin
            chain_cap <= {bus.bsr_si, chain_cap[7:1]};
            sh_cnt    <= sh_cnt + 1;
         end else begin
            chain_cap <= pins;
            cap_cnt   <= cap_cnt + 1;
         end
      end
      if (bus.update_dr) begin
         chain_upd <= chain_cap;
         upd_cnt   <= upd_cnt + 1;
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout required=finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One full tck period; returns tdo as it stands after the falling edge.
   task automatic pulse(input logic t_ms, input logic t_di, output logic t_do);
      bus.tms = t_ms;
      bus.tdi = t_di;
      repeat (4) @(posedge iclk);
      #1 bus.tck = 1'b1;
      repeat (4) @(posedge iclk);
      #1 bus.tck = 1'b0;
      repeat (4) @(posedge iclk);
      #1;
      t_do = bus.tdo;
      st_m = t_ms ? NS1[int'(st_m)*4 +: 4] : NS0[int'(st_m)*4 +: 4];
      check("tap_state", {28'h0, bus.tap_state}, {28'h0, st_m});
   endtask

   // From RTI: scan len bits of data through IR or DR, return the bits seen on tdo.
   task automatic scan(input logic is_ir, input int len, input logic [31:0] data,
                       output logic [31:0] cap);
      logic t;
      cap = 32'h0;
      pulse(1'b1, 1'b0, t);
      if (is_ir) pulse(1'b1, 1'b0, t);
      pulse(1'b0, 1'b0, t);
      pulse(1'b0, 1'b0, t);
      cap[0] = t;
      check("tdo_en_shift", {31'h0, bus.tdo_en}, 32'h1);
      for (int i = 0; i < len; i++) begin
         pulse((i == len - 1), data[i], t);
         if (i < len - 1) cap[i+1] = t;
      end
      pulse(1'b1, 1'b0, t);
      pulse(1'b0, 1'b0, t);
      check("tdo_en_idle", {31'h0, bus.tdo_en}, 32'h0);
   endtask

   function automatic logic [7:0] exp_dr(input logic [3:0] op, input logic [7:0] d,
                                         input logic [7:0] p);
      if ((op == 4'b0000) || (op == 4'b0001)) return p;
`ifdef DP_TAP_IDCODE_EN
      if (op == 4'b0010) return IDV[7:0];
`endif
      return {d[6:0], 1'b0};
   endfunction

   task automatic load_ir(input logic [3:0] op);
      logic [31:0] cap;
      scan(1'b1, 4, {28'h0, op}, cap);
      check("ir_capture", cap, 32'h0000_0001);
      check("mode", {31'h0, bus.mode}, {31'h0, (op == 4'b0000)});
   endtask

   task automatic dr_check(input logic [3:0] op, input logic [7:0] data);
      logic [31:0] cap;
      logic        sel;
      int          c0, s0, u0;
      sel  = (op == 4'b0000) || (op == 4'b0001);
      c0   = cap_cnt;
      s0   = sh_cnt;
      u0   = upd_cnt;
      pins = 8'($urandom);
      scan(1'b0, 8, {24'h0, data}, cap);
      check("dr_tdo", cap, {24'h0, exp_dr(op, data, pins)});
      check("clk_dr_capture", cap_cnt - c0, sel ? 1 : 0);
      check("clk_dr_shift", sh_cnt - s0, sel ? 8 : 0);
      check("update_dr", upd_cnt - u0, sel ? 1 : 0);
      if (sel) check("bsr_update", {24'h0, chain_upd}, {24'h0, data});
   endtask

   initial begin
      logic        t;
      logic [3:0]  op;
      logic [31:0] cap;
      int          n;
      bus.tck = 1'b0;
      bus.tms = 1'b1;
      bus.tdi = 1'b0;
      pins    = 8'h00;
      st_m    = S_TLR;
      resetn  = 1'b0;
      repeat (3) @(posedge iclk);
      #1;
      check("rst_state", {28'h0, bus.tap_state}, {28'h0, S_TLR});
      check("rst_tdo", {31'h0, bus.tdo}, 32'h0);
      check("rst_tdo_en", {31'h0, bus.tdo_en}, 32'h0);
      check("rst_shift_dr", {31'h0, bus.shift_dr}, 32'h0);
      check("rst_clk_dr", {31'h0, bus.clk_dr}, 32'h0);
      check("rst_update_dr", {31'h0, bus.update_dr}, 32'h0);
      check("rst_mode", {31'h0, bus.mode}, 32'h0);
      resetn = 1'b1;
      pulse(1'b0, 1'b0, t);
`ifdef DP_TAP_IDCODE_EN
      scan(1'b0, 32, $urandom, cap);
      check("idcode_stream", cap, IDV);
`endif
      dr_check(IR_RST, 8'($urandom));

      load_ir(4'b0000);
      dr_check(4'b0000, 8'hA5);
      load_ir(4'b0001);
      dr_check(4'b0001, 8'($urandom));
      load_ir(4'b1111);
      dr_check(4'b1111, 8'h0D);

      for (int k = 0; k < 10; k++) begin
         op = 4'($urandom_range(0, 15));
         load_ir(op);
         dr_check(op, 8'($urandom));
      end

      // Five tms=1 from SH_IR with EXTEST active must land in TLR with IR reset.
      load_ir(4'b0000);
      pulse(1'b1, 1'b0, t);
      pulse(1'b1, 1'b0, t);
      pulse(1'b0, 1'b0, t);
      pulse(1'b0, 1'b0, t);
      for (int k = 0; k < 5; k++) pulse(1'b1, 1'b0, t);
      check("tlr_from_shir", {28'h0, bus.tap_state}, {28'h0, S_TLR});
      check("tlr_mode", {31'h0, bus.mode}, 32'h0);
      pulse(1'b0, 1'b0, t);
      dr_check(IR_RST, 8'($urandom));

      for (int k = 0; k < 4; k++) begin
         n = $urandom_range(1, 12);
         for (int j = 0; j < n; j++) pulse(1'($urandom), 1'($urandom), t);
         for (int j = 0; j < 5; j++) pulse(1'b1, 1'b0, t);
         check("tlr_walk", {28'h0, bus.tap_state}, {28'h0, S_TLR});
         check("tlr_walk_mode", {31'h0, bus.mode}, 32'h0);
         pulse(1'b0, 1'b0, t);
      end

      // Asynchronous reset in the middle of an EXTEST DR shift.
      load_ir(4'b0000);
      pins = 8'hFF;
      pulse(1'b1, 1'b0, t);
      pulse(1'b0, 1'b0, t);
      pulse(1'b0, 1'b0, t);
      pulse(1'b0, 1'b1, t);
      check("pre_rst_shift_dr", {31'h0, bus.shift_dr}, 32'h1);
      check("pre_rst_tdo", {31'h0, bus.tdo}, 32'h1);
      @(posedge iclk);
      #2 resetn = 1'b0;
      #1;
      check("midrst_state", {28'h0, bus.tap_state}, {28'h0, S_TLR});
      check("midrst_tdo", {31'h0, bus.tdo}, 32'h0);
      check("midrst_shift_dr", {31'h0, bus.shift_dr}, 32'h0);
      check("midrst_mode", {31'h0, bus.mode}, 32'h0);
      check("midrst_tdo_en", {31'h0, bus.tdo_en}, 32'h0);
      repeat (2) @(posedge iclk);
      #1 resetn = 1'b1;
      st_m = S_TLR;
      pulse(1'b0, 1'b0, t);
      check("post_rst_rti", {28'h0, bus.tap_state}, {28'h0, S_RTI});
      dr_check(IR_RST, 8'($urandom));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
